// File: rtl/keypad_responder_if.sv
// Request/status bundle between a key-sequence source and keypad_responder.
interface keypad_responder_if #(
  parameter int HOLD_W = 8
);
  logic              key_valid;
  logic [3:0]        key_code;
  logic [HOLD_W-1:0] hold_scans;
  logic              key_ready;
  logic              busy;
  logic              done;
  logic              err;

  modport master (output key_valid, key_code, hold_scans,
                  input  key_ready, busy, done, err);
  modport slave  (input  key_valid, key_code, hold_scans,
                  output key_ready, busy, done, err);
endinterface

// File: rtl/keypad_responder.sv
// Behavioural 3x4 keypad: drives active-low columns against the scanner's row select.
// Optional macro KEYPAD_BOUNCE_EN adds a 4-round contact-bounce phase before each press.
module keypad_responder #(
  parameter int HOLD_W    = 8,
  parameter int REL_SCANS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        sel,
  output logic [2:0]        column,
  keypad_responder_if.slave req
);
  localparam int RW = $clog2(REL_SCANS + 1);
  localparam int CW = (HOLD_W > RW) ? HOLD_W : RW;

`ifdef KEYPAD_BOUNCE_EN
  typedef enum logic [2:0] {IDLE, ARM, BOUNCE, PRESS, RELEASE} state_t;
`else
  typedef enum logic [2:0] {IDLE, ARM, PRESS, RELEASE} state_t;
`endif

  state_t            state;
  logic [2:0]        sel_q, pat_q, pat_d;
  logic [1:0]        row_q, row_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CW-1:0]     cnt;
  logic              legal, round_start, row_hit;
  logic              ready_q, busy_q, done_q, err_q;

  assign round_start = (sel == 3'd0) && (sel_q != 3'd0);
  assign row_hit     = (sel == {1'b0, row_q});
  assign hold_d      = (req.hold_scans == '0) ? HOLD_W'(1) : req.hold_scans;

  assign req.key_ready = ready_q;
  assign req.busy      = busy_q;
  assign req.done      = done_q;
  assign req.err       = err_q;

  always_comb begin
    legal = 1'b1;
    row_d = 2'd0;
    pat_d = 3'b111;
    case (req.key_code)
      4'd1:  begin row_d = 2'd0; pat_d = 3'b011; end
      4'd2:  begin row_d = 2'd0; pat_d = 3'b101; end
      4'd3:  begin row_d = 2'd0; pat_d = 3'b110; end
      4'd4:  begin row_d = 2'd1; pat_d = 3'b011; end
      4'd5:  begin row_d = 2'd1; pat_d = 3'b101; end
      4'd6:  begin row_d = 2'd1; pat_d = 3'b110; end
      4'd7:  begin row_d = 2'd2; pat_d = 3'b011; end
      4'd8:  begin row_d = 2'd2; pat_d = 3'b101; end
      4'd9:  begin row_d = 2'd2; pat_d = 3'b110; end
      4'd10: begin row_d = 2'd3; pat_d = 3'b011; end
      4'd0:  begin row_d = 2'd3; pat_d = 3'b101; end
      4'd11: begin row_d = 2'd3; pat_d = 3'b110; end
      default: legal = 1'b0;
    endcase
  end

  // Combinational from live sel so the scanner sees the key in the same slot it selects.
  always_comb begin
    column = 3'b111;
    if (state == PRESS && row_hit) column = pat_q;
`ifdef KEYPAD_BOUNCE_EN
    if (state == BOUNCE && row_hit && !cnt[0]) column = pat_q;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sel_q   <= 3'd0;
      cnt     <= '0;
      row_q   <= 2'd0;
      pat_q   <= 3'b111;
      hold_q  <= HOLD_W'(1);
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sel_q  <= sel;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: if (req.key_valid) begin
          if (legal) begin
            row_q   <= row_d;
            pat_q   <= pat_d;
            hold_q  <= hold_d;
            state   <= ARM;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
        ARM: if (round_start) begin
          cnt <= '0;
`ifdef KEYPAD_BOUNCE_EN
          state <= BOUNCE;
`else
          state <= PRESS;
`endif
        end
`ifdef KEYPAD_BOUNCE_EN
        BOUNCE: if (round_start) begin
          if (cnt == CW'(3)) begin
            cnt   <= '0;
            state <= PRESS;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        PRESS: if (round_start) begin
          if (cnt == CW'(hold_q - HOLD_W'(1))) begin
            cnt   <= '0;
            state <= RELEASE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE: if (round_start) begin
          if (cnt == CW'(REL_SCANS - 1)) begin
            cnt     <= '0;
            state   <= IDLE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_responder.sv
// Self-checking bench for keypad_responder: a free-running 0..5 scanner plus a
// round-counting reference model of press timing and key-map decode.
module tb_keypad_responder;
  localparam int HOLD_W = 8;
  localparam int REL    = 8;
`ifdef KEYPAD_BOUNCE_EN
  localparam int BNC_RND = 4;
  localparam int BNC_AS  = 2;
`else
  localparam int BNC_RND = 0;
  localparam int BNC_AS  = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] sel = 3'd0;
  logic [2:0] column;

  keypad_responder_if #(.HOLD_W(HOLD_W)) kif ();

  keypad_responder #(.HOLD_W(HOLD_W), .REL_SCANS(REL)) dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .column (column),
    .req    (kif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Scanner: sel steps 0..5 once per clock, changed just after the edge.
  initial forever begin
    @(posedge clk);
    #1 sel = (sel == 3'd5) ? 3'd0 : sel + 3'd1;
  end

  // Monitor state (written only here); tasks take snapshots and compare deltas.
  logic [2:0] m_prev;
  logic [3:0] exp_row = 4'd0;
  logic [2:0] exp_pat = 3'b111;
  int n_assert = 0, n_bad = 0, n_rb_bad = 0, rs_cnt = 0;
  int cyc = 0, last_rs_cyc = 0, done_rs = 0, done_gap = 0;

  always @(posedge clk or posedge reset)
    if (reset) m_prev <= 3'd0;
    else       m_prev <= sel;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (kif.done) begin
        done_rs  = rs_cnt;
        done_gap = cyc - last_rs_cyc;
      end
      if (sel == 3'd0 && m_prev != 3'd0) begin
        rs_cnt++;
        last_rs_cyc = cyc;
      end
      if (column != 3'b111) begin
        n_assert++;
        if ({1'b0, sel} != exp_row || column != exp_pat) n_bad++;
      end
      if (kif.key_ready === kif.busy) n_rb_bad++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int w = 0;
    while (kif.key_ready !== 1'b1 && w < 300) begin step(); w++; end
    checks++;
    if (kif.key_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_wait: key_ready=%b required 1", name, kif.key_ready);
    end
  endtask

  // One press transaction checked against the key map and round-count timing.
  task automatic press(input int code, input int hold, input int noise, input bit b2b,
                       input string name);
    int h, row, col, lim, b_as, b_bad, b_rs, b_rb, w;
    bit seen;
    h   = (hold == 0) ? 1 : hold;
    row = (code == 0 || code >= 10) ? 3 : (code - 1) / 3;
    col = (code == 0) ? 1 : (code == 10) ? 0 : (code == 11) ? 2 : (code - 1) % 3;
    wait_ready(name);
    exp_row = 4'(row);
    exp_pat = ~(3'b100 >> col);
    b_as = n_assert; b_bad = n_bad; b_rs = rs_cnt; b_rb = n_rb_bad;
    kif.key_valid  = 1'b1;
    kif.key_code   = 4'(code);
    kif.hold_scans = HOLD_W'(hold);
    step();
    checks++;
    if (kif.key_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_fall: key_ready=%b required 0", name, kif.key_ready);
    end
    if (noise > 0) kif.key_code = 4'd9;
    seen = 1'b0; w = 0;
    lim  = (1 + h + REL + BNC_RND + 2) * 6 + 20;
    while (!seen && w < lim) begin
      if (w >= noise) kif.key_valid = 1'b0;
      step(); w++;
      if (kif.done === 1'b1) seen = 1'b1;
    end
    kif.key_valid = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: no done within %0d cycles", name, lim);
    end
    checks++;
    if (done_rs - b_rs != 1 + h + REL + BNC_RND || done_gap != 1) begin
      errors++;
      $display("FAIL %s done_timing: rounds=%0d gap=%0d required rounds=%0d gap=1",
               name, done_rs - b_rs, done_gap, 1 + h + REL + BNC_RND);
    end
    checks++;
    if (n_assert - b_as != h + BNC_AS) begin
      errors++;
      $display("FAIL %s assert_count: got %0d required %0d", name, n_assert - b_as, h + BNC_AS);
    end
    checks++;
    if (n_bad != b_bad) begin
      errors++;
      $display("FAIL %s wrong_slot: %0d bad column cycles required 0 (row %0d pat %b)",
               name, n_bad - b_bad, row, exp_pat);
    end
    checks++;
    if (kif.key_ready !== 1'b1 || kif.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_status: ready=%b busy=%b required 1/0", name, kif.key_ready, kif.busy);
    end
    checks++;
    if (n_rb_bad != b_rb) begin
      errors++;
      $display("FAIL %s ready_busy: %0d cycles with ready==busy required 0", name, n_rb_bad - b_rb);
    end
    if (!b2b) begin
      step();
      checks++;
      if (kif.done !== 1'b0) begin
        errors++;
        $display("FAIL %s done_width: done=%b required 0", name, kif.done);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (column !== 3'b111 || kif.key_ready !== 1'b1 || kif.busy !== 1'b0 ||
        kif.done !== 1'b0 || kif.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: col=%b rdy=%b busy=%b done=%b err=%b required 111/1/0/0/0",
               column, kif.key_ready, kif.busy, kif.done, kif.err);
    end
  endtask

  task automatic test_basic();
    press(2, 3, 0, 1'b0, "basic");
  endtask

  task automatic test_decode();
    press(4, 1, 0, 1'b0, "decode4");
    press(6, 1, 0, 1'b0, "decode6");
    press(8, 1, 0, 1'b0, "decode8");
  endtask

  task automatic test_reject();
    int b_as;
    wait_ready("reject");
    b_as = n_assert;
    kif.key_valid = 1'b1;
    kif.key_code  = 4'($urandom_range(12, 15));
    kif.hold_scans = HOLD_W'(2);
    step();
    kif.key_valid = 1'b0;
    checks++;
    if (kif.err !== 1'b1 || kif.key_ready !== 1'b1 || column !== 3'b111) begin
      errors++;
      $display("FAIL reject_err: err=%b ready=%b col=%b required 1/1/111",
               kif.err, kif.key_ready, column);
    end
    step();
    checks++;
    if (kif.err !== 1'b0) begin
      errors++;
      $display("FAIL reject_err_width: err=%b required 0", kif.err);
    end
    repeat (12) step();
    checks++;
    if (n_assert != b_as || kif.busy !== 1'b0) begin
      errors++;
      $display("FAIL reject_idle: asserts=%0d busy=%b required 0/0", n_assert - b_as, kif.busy);
    end
  endtask

  task automatic test_hold_zero_busy();
    press(5, 0, 20, 1'b0, "hold0_busy");
  endtask

  task automatic test_back_to_back();
    press(7, 2, 0, 1'b1, "b2b_a");
    press(11, 1, 0, 1'b1, "b2b_b");
    press(0, 1, 0, 1'b0, "b2b_c");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      press(int'($urandom_range(0, 11)), int'($urandom_range(0, 3)), 0, 1'b0, "random");
  endtask

  task automatic test_reset_mid_press();
    int w = 0;
    wait_ready("midreset");
    exp_row = 4'd0;
    exp_pat = 3'b011;
    kif.key_valid  = 1'b1;
    kif.key_code   = 4'd1;
    kif.hold_scans = HOLD_W'(5);
    step();
    kif.key_valid = 1'b0;
    while (!(sel == 3'd0 && column != 3'b111) && w < 100) begin step(); w++; end
    checks++;
    if (column !== 3'b011 || sel !== 3'd0) begin
      errors++;
      $display("FAIL midreset_press: col=%b sel=%0d required 011 at sel 0", column, sel);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (column !== 3'b111 || kif.busy !== 1'b0 || kif.key_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async: col=%b busy=%b ready=%b required 111/0/1",
               column, kif.busy, kif.key_ready);
    end
    step();
    reset = 1'b0;
    repeat (8) step();
    checks++;
    if (column !== 3'b111 || kif.busy !== 1'b0 || kif.key_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_after: col=%b busy=%b ready=%b required 111/0/1",
               column, kif.busy, kif.key_ready);
    end
  endtask

`ifdef KEYPAD_BOUNCE_EN
  task automatic test_bounce();
    press(8, 2, 0, 1'b0, "bounce");
  endtask
`endif

  initial begin
    kif.key_valid  = 1'b0;
    kif.key_code   = 4'd0;
    kif.hold_scans = '0;
    reset = 1'b1;
    repeat (3) step();
    test_reset();
    reset = 1'b0;
    step();
    test_basic();
    test_decode();
    test_reject();
    test_hold_zero_busy();
    test_back_to_back();
    test_random();
    test_reset_mid_press();
`ifdef KEYPAD_BOUNCE_EN
    test_bounce();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
